fifo_rd_stream: RTL

//  Read-side drain engine for the FIFO read port (rinc/rempty/rdata with 1-cycle registered read data).

---
 rtl/fifo_rd_pkg.sv | 20 ++
 rtl/stream_skid_buf.sv | 94 +++++++++
 rtl/fifo_rd_stream.sv | 91 +++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg
//   Shared definitions for the FIFO read-side drain engine.
//   - DEF_WIDTH / DEF_SKID_DEPTH : default word width and skid depth
//   - PTR_W                      : ring pointer width for the default depth
//   - word_t                     : stream word type at the default width
//   - level_w()                  : occupancy counter width for a given depth
package fifo_rd_pkg;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_SKID_DEPTH = 2;
   localparam int PTR_W          = $clog2(DEF_SKID_DEPTH);

   typedef logic [DEF_WIDTH-1:0] word_t;

   // Occupancy runs 0..depth inclusive, so it needs one bit more than a pointer.
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf
//   Synchronous DEPTH-entry ring buffer with a registered head word.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     clear     : drop all contents (pointers and level to zero)
//     push      : write wdata at the tail this cycle
//     wdata     : tail write data
//     pop       : remove the head this cycle (only while level != 0)
//     rdata     : registered head word
//     level     : current occupancy
module stream_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_SKID_DEPTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      push,
   input  logic [WIDTH-1:0]          wdata,
   input  logic                      pop,
   output logic [WIDTH-1:0]          rdata,
   output logic [level_w(DEPTH)-1:0] level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = level_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [PW-1:0]    rd_nxt;

   always_comb begin
      rd_nxt   = rd_ptr_q + PW'(1);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      head_d   = head_q;

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_nxt;

      if (push && !pop)      level_d = level_q + LW'(1);
      else if (!push && pop) level_d = level_q - LW'(1);

      // Keep the head register pointing at the next word to present. When
      // the only stored word leaves while a new one arrives, the new word
      // is not in the ring yet, so it is taken straight from wdata.
      if (pop) begin
         if (push && level_q == LW'(1)) head_d = wdata;
         else                           head_d = mem[rd_nxt];
      end else if (push && level_q == '0) begin
         head_d = wdata;
      end

      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         head_d   = head_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
      end
   end

   // Storage carries no reset; only the pointers say what is valid.
   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr_q] <= wdata;
   end

   // Capturing into a full ring means the pop-issue accounting is broken.
   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(push && !clear && !pop && level_q == LW'(DEPTH)));

   assign rdata = head_q;
   assign level = level_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Drains a FIFO read port (rinc/rempty/rdata, one-cycle registered read
//   data) into a valid/ready stream through a small skid buffer, so a
//   continuously ready sink receives one word per cycle.
//   Ports:
//     clk, rst   : read clock, synchronous active-high reset
//     rinc       : FIFO pop request (combinational from m_ready)
//     rempty     : FIFO empty flag
//     rdata      : FIFO read data, valid the cycle after an accepted pop
//     flush      : drop buffered and in-flight words; stalls popping while high
//     m_valid, m_ready, m_data : output stream
//     level      : skid buffer occupancy
//     pop_count  : delivered-word counter, wraps
module fifo_rd_stream
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int SKID_DEPTH = DEF_SKID_DEPTH,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        rinc,
   input  logic                        rempty,
   input  logic [WIDTH-1:0]            rdata,
   input  logic                        flush,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [WIDTH-1:0]            m_data,
   output logic [$clog2(SKID_DEPTH):0] level,
   output logic [CNT_WIDTH-1:0]        pop_count
);

   localparam int LVL_W = level_w(SKID_DEPTH);

   logic                 inflight_q, inflight_d;
   logic                 drop_q, drop_d;
   logic [CNT_WIDTH-1:0] pop_count_q, pop_count_d;
   logic [LVL_W-1:0]     used;
   logic                 deliver;
   logic                 pop_acc;
   logic                 capture;

   always_comb begin
      used    = level + LVL_W'(inflight_q);
      deliver = m_valid & m_ready;

      // A slot is free either outright or because the head leaves this cycle.
      rinc = !rst & !rempty & !flush &
             ((used < LVL_W'(SKID_DEPTH)) |
              ((used == LVL_W'(SKID_DEPTH)) & deliver));

      pop_acc     = rinc & !rempty;
      inflight_d  = pop_acc;
      // The drop flag marks a word whose read data returns after the flush
      // edge; a word returning in the flush cycle itself is blocked below.
      drop_d      = flush & (inflight_q | pop_acc);
      capture     = inflight_q & !drop_q & !flush;
      pop_count_d = pop_count_q + CNT_WIDTH'(deliver);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q  <= 1'b0;
         drop_q      <= 1'b0;
         pop_count_q <= '0;
      end else begin
         inflight_q  <= inflight_d;
         drop_q      <= drop_d;
         pop_count_q <= pop_count_d;
      end
   end

   stream_skid_buf #(
      .WIDTH (WIDTH),
      .DEPTH (SKID_DEPTH)
   ) u_skid (
      .clk   (clk),
      .rst   (rst),
      .clear (flush),
      .push  (capture),
      .wdata (rdata),
      .pop   (deliver),
      .rdata (m_data),
      .level (level)
   );

   assign m_valid   = (level != '0);
   assign pop_count = pop_count_q;

endmodule
